// File: rtl/fifo_pkg.sv
// Shared definitions for the single-port-SRAM FIFO and its read-side controller.
package fifo_pkg;

    localparam int FIFO_RD_LATENCY = 1;
    localparam int FIFO_WIDTH      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus downstream valid/ready stream, as seen by the reader (master)
// and by the FIFO/consumer environment (slave).
interface fifo_reader_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
);
    logic             fifo_empty;
    logic             fifo_we_n;
    logic             fifo_oe_n;
    logic [WIDTH-1:0] fifo_dout;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (
        input  fifo_empty, fifo_we_n, fifo_dout, m_ready,
        output fifo_oe_n, m_data, m_valid
    );

    modport slave (
        output fifo_empty, fifo_we_n, fifo_dout, m_ready,
        input  fifo_oe_n, m_data, m_valid
    );
endinterface

// File: rtl/fifo_reader_buf.sv
// Small in-order flop FIFO; head word is presented from a register, never fall-through.
module fifo_reader_buf #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && o_full));

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller: strobes the SRAM FIFO under a credit limit, tracks reads in flight,
// and hands captured words downstream through a small valid/ready buffer.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH      = FIFO_WIDTH,
    parameter int RD_LATENCY = FIFO_RD_LATENCY,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    fifo_reader_if.master        bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] rd_count
);
    localparam int BUF_DEPTH = RD_LATENCY + 1;
    localparam int CW        = $clog2(BUF_DEPTH + 1);

    if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_latency
        $error("fifo_reader: RD_LATENCY must be 1 or 2");
    end

    state_t                r_state;
    state_t                w_state_next;
    logic [RD_LATENCY-1:0] r_inflight;
    logic [CNT_WIDTH-1:0]  r_rd_count;
    logic [CW-1:0]         w_inflight_cnt;
    logic [CW-1:0]         w_buf_count;
    logic [CW:0]           w_committed;
    logic [CW:0]           w_limit;
    logic                  w_rd;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_buf_full;
    logic                  w_buf_empty;

    always_comb begin
        w_inflight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight_cnt = w_inflight_cnt + CW'(r_inflight[i]);
        end
    end

    // A word popped this cycle frees its slot at the same edge, which keeps one read per cycle.
    assign w_committed = {1'b0, w_buf_count} + {1'b0, w_inflight_cnt};
    assign w_limit     = (CW + 1)'(BUF_DEPTH) + {{CW{1'b0}}, w_pop};

    assign w_rd = rst_n && (r_state == RUN) && enable && !bus.fifo_empty
               && bus.fifo_we_n && (w_committed < w_limit);

    assign bus.fifo_oe_n = !w_rd;
    assign w_push        = r_inflight[RD_LATENCY-1];
    assign w_pop         = !w_buf_empty && bus.m_ready;
    assign bus.m_valid   = !w_buf_empty;
    assign busy          = (r_state != IDLE);
    assign rd_count      = r_rd_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_inflight <= '0;
            r_rd_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_inflight[0] <= w_rd;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_inflight[i] <= r_inflight[i-1];
            end
            if (w_pop) begin
                r_rd_count <= r_rd_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (enable) w_state_next = RUN;
            RUN:     if (!enable) w_state_next = STOP;
            STOP: begin
                if (enable) begin
                    w_state_next = RUN;
                end else if (w_inflight_cnt == '0 && w_buf_empty) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    fifo_reader_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (bus.fifo_dout),
        .i_pop   (w_pop),
        .o_data  (bus.m_data),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty),
        .o_count (w_buf_count)
    );

    // Credits cap buffered plus in-flight words at BUF_DEPTH, so a full buffer has nothing in flight.
    a_full_no_inflight: assert property (@(posedge clk) disable iff (!rst_n)
                                         w_buf_full |-> (w_inflight_cnt == '0));

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a behavioural SRAM FIFO feeds the reader, expected words
// are queued at load time and a negedge monitor checks every downstream transfer.
module tb_fifo_reader;
    import fifo_pkg::*;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        busy;
    logic [15:0] rd_count;

    fifo_reader_if #(.WIDTH(W)) bus();

    fifo_reader #(
        .WIDTH      (W),
        .RD_LATENCY (1),
        .CNT_WIDTH  (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .bus      (bus),
        .busy     (busy),
        .rd_count (rd_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [W-1:0] mem_q[$];
    logic [W-1:0] exp_q[$];

    int strobe_cnt, run_len, max_run;
    int deliv_cnt, first_deliv_cyc, last_deliv_cyc, first_strobe_cyc;
    bit hold_pending = 1'b0;
    logic [W-1:0] hold_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Behavioural FIFO: registered read data and registered empty flag.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!bus.fifo_oe_n && bus.fifo_we_n) begin
            if (mem_q.size() == 0) check("strobe_on_empty", 1, 0);
            else bus.fifo_dout <= mem_q.pop_front();
        end
        bus.fifo_empty <= (mem_q.size() == 0);
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.fifo_oe_n === 1'b0) begin
                strobe_cnt++;
                if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (hold_pending) begin
                check("hold_valid", bus.m_valid, 1);
                check("hold_data", bus.m_data, hold_data);
            end
            hold_pending = bus.m_valid && !bus.m_ready;
            hold_data    = bus.m_data;
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: actual=0x%0h required=none", bus.m_data);
                end else begin
                    check("word", bus.m_data, exp_q.pop_front());
                end
                deliv_cnt++;
                if (first_deliv_cyc < 0) first_deliv_cyc = cyc;
                last_deliv_cyc = cyc;
            end
        end else begin
            hold_pending = 1'b0;
            run_len      = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] d, input bit expect_out);
        mem_q.push_back(d);
        if (expect_out) exp_q.push_back(d);
    endtask

    task automatic clear_stats();
        strobe_cnt = 0; run_len = 0; max_run = 0; deliv_cnt = 0;
        first_deliv_cyc = -1; last_deliv_cyc = -1; first_strobe_cyc = -1;
    endtask

    task automatic wait_deliv(input int n, input string name);
        int b = 0;
        while (deliv_cnt < n && b < 50) begin step(); b++; end
        check(name, deliv_cnt, n);
    endtask

    task automatic wait_strobe(input string name);
        int b = 0;
        while (strobe_cnt == 0 && b < 20) begin step(); b++; end
        check(name, strobe_cnt, 1);
    endtask

    initial begin
        int b;
        int busy_fall;
        rst_n = 1'b0; enable = 1'b1; bus.fifo_we_n = 1'b1; bus.m_ready = 1'b1;
        clear_stats();
        load(8'h11, 1); load(8'h22, 1); load(8'h33, 1);
        repeat (3) step();
        @(negedge clk);
        check("reset_oe_n", bus.fifo_oe_n, 1);
        check("reset_valid", bus.m_valid, 0);
        check("reset_count", rd_count, 0);
        check("reset_busy", busy, 0);

        // Streaming
        step();
        clear_stats();
        rst_n = 1'b1;
        wait_deliv(3, "strm_delivered");
        repeat (3) step();
        check("strm_strobes", strobe_cnt, 3);
        check("strm_consec_strobes", max_run, 3);
        check("strm_latency", first_deliv_cyc - first_strobe_cyc, 2);
        check("strm_consec_words", last_deliv_cyc - first_deliv_cyc, 2);
        check("strm_count", rd_count, 3);
        check("strm_oe_after_empty", bus.fifo_oe_n, 1);

        // Backpressure
        bus.m_ready = 1'b0;
        clear_stats();
        load(8'hA1, 1); load(8'hA2, 1); load(8'hA3, 1); load(8'hA4, 1); load(8'hA5, 1);
        repeat (8) step();
        check("bp_strobes", strobe_cnt, 2);
        check("bp_oe_n", bus.fifo_oe_n, 1);
        check("bp_valid", bus.m_valid, 1);
        check("bp_head", bus.m_data, 8'hA1);
        check("bp_count", rd_count, 3);
        bus.m_ready = 1'b1;
        wait_deliv(5, "bp_delivered");
        repeat (3) step();
        check("bp_strobes_total", strobe_cnt, 5);
        check("bp_count_final", rd_count, 8);

        // Collision with the writer
        clear_stats();
        bus.fifo_we_n = 1'b0;
        load(8'hC1, 1); load(8'hC2, 1); load(8'hC3, 1); load(8'hC4, 1);
        step();
        check("coll_oe_n_0", bus.fifo_oe_n, 1);
        step();
        check("coll_oe_n_1", bus.fifo_oe_n, 1);
        step();
        bus.fifo_we_n = 1'b1;
        #1;
        check("coll_resume", bus.fifo_oe_n, 0);
        wait_deliv(4, "coll_delivered");
        repeat (3) step();
        check("coll_count", rd_count, 12);

        // Stop and drain
        clear_stats();
        load(8'hD1, 1); load(8'hD2, 0); load(8'hD3, 0);
        wait_strobe("drain_first_strobe");
        enable = 1'b0;
        b = 0;
        while (busy !== 1'b0 && b < 20) begin step(); b++; end
        busy_fall = cyc;
        check("drain_busy", busy, 0);
        check("drain_busy_timing", busy_fall - last_deliv_cyc, 2);
        check("drain_strobes", strobe_cnt, 1);
        check("drain_delivered", deliv_cnt, 1);
        check("drain_count", rd_count, 13);
        check("drain_valid", bus.m_valid, 0);

        // Reset with a read in flight (D2 is strobed but must never appear)
        clear_stats();
        enable = 1'b1;
        wait_strobe("mid_strobe");
        rst_n = 1'b0;
        enable = 1'b0;
        step();
        check("mid_valid", bus.m_valid, 0);
        check("mid_count", rd_count, 0);
        check("mid_oe_n", bus.fifo_oe_n, 1);
        check("mid_busy", busy, 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (4) step();
        check("mid_no_delivery", deliv_cnt, 0);
        check("mid_valid_after", bus.m_valid, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
